// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo types and sizing constants for the add/sub/logic
// reservation-station bank.
package tomasulo_pkg;

    localparam int no_RS_addsublog = 8;
    localparam int CDB_PORTS       = 3;
    localparam int ROB_TAG_W       = 6;
    localparam int RS_XLEN         = 32;
    localparam int RS_OP_W         = 4;

    typedef struct packed {
        logic                 busy;
        logic                 ready;
        logic [RS_OP_W-1:0]   op;
        logic [RS_XLEN-1:0]   Vj;
        logic [RS_XLEN-1:0]   Vk;
        logic [ROB_TAG_W-1:0] Qj;
        logic [ROB_TAG_W-1:0] Qk;
        logic                 qj_pend;
        logic                 qk_pend;
        logic [ROB_TAG_W-1:0] ROB_index;
    } AddSub_RS_Entry_t;

    // Result of searching the CDB for one tag.
    typedef struct packed {
        logic               hit;
        logic [RS_XLEN-1:0] data;
    } CdbHit_t;

endpackage

// File: rtl/alu_rs_bank_free_alloc.sv
// Multi-grant find-first-free allocator: each valid dispatch slot, in slot
// order, claims the lowest entry not busy and not already claimed.
module rs_free_alloc #(
    parameter int NUM_RS         = 8,
    parameter int DISPATCH_WIDTH = 3
) (
    input  logic [NUM_RS-1:0]                      busy_i,
    input  logic [DISPATCH_WIDTH-1:0]              disp_valid_i,
    output logic [DISPATCH_WIDTH-1:0][NUM_RS-1:0]  grant_o,
    output logic                                   stall_o
);

    logic [NUM_RS-1:0] claimed;
    logic              found;
    int                reqCnt;
    int                freeCnt;

    // All-or-nothing: when the request outnumbers free entries no slot is granted.
    always_comb begin
        claimed = busy_i;
        grant_o = '0;
        found   = 1'b0;
        reqCnt  = 0;
        freeCnt = 0;
        for (int e = 0; e < NUM_RS; e++) begin
            if (!busy_i[e]) freeCnt++;
        end
        for (int s = 0; s < DISPATCH_WIDTH; s++) begin
            if (disp_valid_i[s]) reqCnt++;
        end
        stall_o = (reqCnt > freeCnt);
        for (int s = 0; s < DISPATCH_WIDTH; s++) begin
            found = 1'b0;
            if (disp_valid_i[s] && !stall_o) begin
                for (int e = 0; e < NUM_RS; e++) begin
                    if (!claimed[e] && !found) begin
                        grant_o[s][e] = 1'b1;
                        claimed[e]    = 1'b1;
                        found         = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/alu_rs_bank.sv
// Reservation-station bank for add/sub/logic ops: dispatch allocation,
// CDB wakeup with dispatch bypass, and selector-driven deallocation.
module alu_rs_bank
    import tomasulo_pkg::*;
#(
    parameter int NUM_RS         = no_RS_addsublog,
    parameter int DISPATCH_WIDTH = 3,
    parameter int CDB_WIDTH      = CDB_PORTS,
    parameter int XLEN           = RS_XLEN,
    parameter int ROB_IDX_W      = ROB_TAG_W,
    parameter int OP_W           = RS_OP_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [DISPATCH_WIDTH-1:0]            disp_valid,
    input  AddSub_RS_Entry_t [DISPATCH_WIDTH-1:0] disp_entry,
    output logic                                 disp_stall,
    output logic [$clog2(NUM_RS+1)-1:0]          rs_free_cnt,
    input  logic [CDB_WIDTH-1:0]                 cdb_valid,
    input  logic [CDB_WIDTH-1:0][ROB_IDX_W-1:0]  cdb_tag,
    input  logic [CDB_WIDTH-1:0][XLEN-1:0]       cdb_data,
    input  logic [NUM_RS-1:0]                    rs_clear,
    output AddSub_RS_Entry_t [NUM_RS-1:0]         rs_entries
);

    localparam int CntW = $clog2(NUM_RS + 1);

    // The entry struct is sized by the package, so the overridable widths must agree with it.
    if (XLEN != RS_XLEN || ROB_IDX_W != ROB_TAG_W || OP_W != RS_OP_W) begin : gBadParams
        $error("alu_rs_bank: XLEN/ROB_IDX_W/OP_W must match tomasulo_pkg");
    end

    AddSub_RS_Entry_t [NUM_RS-1:0]               entries_q;
    AddSub_RS_Entry_t [NUM_RS-1:0]               entries_d;
    logic [NUM_RS-1:0]                           busyVec;
    logic [DISPATCH_WIDTH-1:0][NUM_RS-1:0]       slotGrant;
    logic                                        allocStall;
    CdbHit_t                                     wakeJ [NUM_RS];
    CdbHit_t                                     wakeK [NUM_RS];
    CdbHit_t                                     slotJ [DISPATCH_WIDTH];
    CdbHit_t                                     slotK [DISPATCH_WIDTH];

    // Lowest-indexed matching port wins; matching ports carry identical data anyway.
    function automatic CdbHit_t cdbLookup(
        input logic [ROB_IDX_W-1:0]                tag,
        input logic [CDB_WIDTH-1:0]                valid,
        input logic [CDB_WIDTH-1:0][ROB_IDX_W-1:0] tags,
        input logic [CDB_WIDTH-1:0][XLEN-1:0]      data
    );
        CdbHit_t r;
        r = '0;
        for (int p = CDB_WIDTH - 1; p >= 0; p--) begin
            if (valid[p] && tags[p] == tag) begin
                r.hit  = 1'b1;
                r.data = data[p];
            end
        end
        return r;
    endfunction

    for (genvar e = 0; e < NUM_RS; e++) begin : gEntry
        assign busyVec[e] = entries_q[e].busy;
        assign wakeJ[e]   = cdbLookup(entries_q[e].Qj, cdb_valid, cdb_tag, cdb_data);
        assign wakeK[e]   = cdbLookup(entries_q[e].Qk, cdb_valid, cdb_tag, cdb_data);
    end

    for (genvar s = 0; s < DISPATCH_WIDTH; s++) begin : gSlot
        assign slotJ[s] = cdbLookup(disp_entry[s].Qj, cdb_valid, cdb_tag, cdb_data);
        assign slotK[s] = cdbLookup(disp_entry[s].Qk, cdb_valid, cdb_tag, cdb_data);
    end

    rs_free_alloc #(
        .NUM_RS         (NUM_RS),
        .DISPATCH_WIDTH (DISPATCH_WIDTH)
    ) uFreeAlloc (
        .busy_i       (busyVec),
        .disp_valid_i (disp_valid),
        .grant_o      (slotGrant),
        .stall_o      (allocStall)
    );

    assign disp_stall  = allocStall;
    assign rs_free_cnt = CntW'(NUM_RS) - CntW'($countones(busyVec));
    assign rs_entries  = entries_q;

    // Clear beats wakeup; allocation only ever targets entries that were free, so it never meets a clear.
    always_comb begin
        entries_d = entries_q;
        for (int e = 0; e < NUM_RS; e++) begin
            if (entries_q[e].busy && rs_clear[e]) begin
                entries_d[e].busy = 1'b0;
            end else if (entries_q[e].busy) begin
                if (entries_q[e].qj_pend && wakeJ[e].hit) begin
                    entries_d[e].Vj      = wakeJ[e].data;
                    entries_d[e].qj_pend = 1'b0;
                end
                if (entries_q[e].qk_pend && wakeK[e].hit) begin
                    entries_d[e].Vk      = wakeK[e].data;
                    entries_d[e].qk_pend = 1'b0;
                end
            end
        end
        if (!flush) begin
            for (int s = 0; s < DISPATCH_WIDTH; s++) begin
                for (int e = 0; e < NUM_RS; e++) begin
                    if (slotGrant[s][e]) begin
                        entries_d[e]      = disp_entry[s];
                        entries_d[e].busy = 1'b1;
                        if (disp_entry[s].qj_pend && slotJ[s].hit) begin
                            entries_d[e].Vj      = slotJ[s].data;
                            entries_d[e].qj_pend = 1'b0;
                        end
                        if (disp_entry[s].qk_pend && slotK[s].hit) begin
                            entries_d[e].Vk      = slotK[s].data;
                            entries_d[e].qk_pend = 1'b0;
                        end
                    end
                end
            end
        end
        for (int e = 0; e < NUM_RS; e++) begin
            entries_d[e].ready = entries_d[e].busy & ~entries_d[e].qj_pend & ~entries_d[e].qk_pend;
            if (flush) begin
                entries_d[e].busy  = 1'b0;
                entries_d[e].ready = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entries_q <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

endmodule

// File: doc/alu_rs_bank.md
Name: alu_rs_bank

Overview:
- Reservation-station storage for the add/sub/logic class of instructions.
- Accepts up to DISPATCH_WIDTH renamed instructions per cycle from the 3-wide rename/dispatch stage.
- Snoops the CDB to wake up pending operands.
- Presents the full entry array to the ALU issue selector and frees entries when that selector returns its per-entry clear vector.

Parameters:
- NUM_RS, 8, number of entries (equals package constant no_RS_addsublog)
- DISPATCH_WIDTH, 3, dispatch slots per cycle
- CDB_WIDTH, 3, CDB broadcast ports per cycle
- XLEN, 32, operand width
- ROB_IDX_W, 6, ROB index / tag width
- OP_W, 4, ALU opcode width

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- flush  in  1  pipeline flush (mispredict/exception)
- disp_valid  in  DISPATCH_WIDTH  per-slot dispatch request
- disp_entry  in  DISPATCH_WIDTH x AddSub_RS_Entry_t  op, Vj/Vk, Qj/Qk, qj_pend/qk_pend, ROB_index (busy/ready fields ignored)
- disp_stall  out  1  requests rejected this cycle
- rs_free_cnt  out  $clog2(NUM_RS+1)  number of non-busy entries (registered state)
- cdb_valid  in  CDB_WIDTH  broadcast valid
- cdb_tag  in  CDB_WIDTH x ROB_IDX_W  producing ROB index
- cdb_data  in  CDB_WIDTH x XLEN  result value
- rs_clear  in  NUM_RS  per-entry deallocate from issue selector
- rs_entries  out  NUM_RS x AddSub_RS_Entry_t  registered entry array to issue selector

Behaviour:
- Reset (rst=1 at posedge): every entry becomes all-zero (busy=0, ready=0, pend=0). rs_entries therefore reads all zero and rs_free_cnt reads NUM_RS. rst overrides flush, dispatch, CDB and clear.
- Flush: at the next posedge all busy bits and all ready bits clear. Dispatch in the same cycle is dropped; disp_stall is don't-care during flush.
- Accept rule: req = popcount(disp_valid). If req > rs_free_cnt, then disp_stall=1 and no slot allocates (all-or-nothing). Otherwise disp_stall=0 and all valid slots allocate.
- disp_stall is combinational from registered state and disp_valid only; entries cleared by rs_clear in the same cycle are not counted as free.
- Allocation order:
  - The lowest-numbered valid slot takes the lowest-numbered free entry, the next valid slot takes the next free entry, and so on.
  - Invalid slots consume no entry.
  - The entry becomes busy at the next posedge; latency dispatch -> visible in rs_entries is 1 cycle.
- Wakeup:
  - For each busy entry and each operand with pend=1, a match against any valid CDB port with cdb_tag==Q loads V<=cdb_data and clears pend at the posedge.
  - Multiple matching ports for the same tag carry identical data; the lowest port index wins.
- Dispatch bypass: an operand arriving with pend=1 whose Q matches a same-cycle CDB broadcast is written with the CDB data and pend=0. Without this bypass the broadcast would be lost.
- ready (registered) = busy & !qj_pend & !qk_pend, computed from next-state values. An entry can therefore become ready in the cycle after dispatch or after a wakeup.
- Clear:
  - rs_clear[i]=1 on a busy entry sets busy=0 and ready=0 at the posedge.
  - rs_clear on a non-busy entry is ignored.
  - A clear takes priority over a wakeup on the same entry.
- No collision between allocate and clear on the same index is possible, because allocation uses only registered-free entries.
- Storage fields of freed entries are don't-care. Only busy and ready must be zero.
- rs_free_cnt = NUM_RS − popcount(busy), registered-state based.

Decomposition:
- tomasulo_pkg holds:
  - AddSub_RS_Entry_t (busy, ready, op, Vj, Vk, Qj, Qk, qj_pend, qk_pend, ROB_index)
  - no_RS_addsublog, CDB width constant, ROB index width
- Sub-module rs_free_alloc: combinational multi-grant find-first-free. Inputs: busy vector and disp_valid. Outputs: per-slot one-hot entry grant and the stall flag.
- Wakeup compare logic stays inline as a generate loop over entries.

Test Plan:
- Reset then idle -> rs_free_cnt=8, disp_stall=0, all rs_entries.busy=0.
- Dispatch 3 slots with both operands ready (ROB 5,6,7) -> next cycle entries 0,1,2 busy=1, ready=1, ROB_index 5,6,7; rs_free_cnt=5.
- Dispatch slot0 with Qj=9, pend=1; two cycles later cdb_valid[1]=1, tag 9, data 0xDEAD_BEEF -> entry ready=0 in between, then Vj=0xDEADBEEF, ready=1 on the following cycle.
- Dispatch with Qk=12 pending while CDB broadcasts tag 12 data 0x55 in the same cycle -> entry captured with Vk=0x55, ready=1 one cycle later.
- Fill 7 entries, request 3 slots -> disp_stall=1, no new entry allocated. Same cycle rs_clear on entry 2 -> entry 2 freed next cycle, free count 2. Retry with 2 slots -> accepted into entries 2 and 7.
- Flush with 5 busy entries plus concurrent dispatch of 2 slots -> next cycle all busy=0, rs_free_cnt=8. Assert rst mid-wakeup -> all entries zero next cycle, CDB capture ignored.
